// File: rtl/ex_div_seq_pkg.sv
// Shared definitions for the EX-stage DIV/DIVU sequencer: state encodings,
// iteration count and the aluop codes EX decodes to launch a division.
package ex_div_seq_pkg;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_DBZ  = 2'b01,
      DIV_ON   = 2'b10,
      DIV_END  = 2'b11
   } div_state_t;

   localparam int DIV_CYCLES = 32;

   localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/ex_div_seq_div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the
// divisor, and keep the difference only when no borrow occurred.
module div_step
   import ex_div_seq_pkg::*;
#(
   parameter int DATA_W = DIV_CYCLES
) (
   input  logic [DATA_W-1:0] rem,
   input  logic [DATA_W-1:0] quo,
   input  logic [DATA_W-1:0] divisor,
   output logic [DATA_W-1:0] rem_next,
   output logic [DATA_W-1:0] quo_next
);

   logic [DATA_W:0] shifted_s;
   logic [DATA_W:0] trial_s;
   logic            borrow_s;

   // rem < divisor always holds, so the top bit of the (DATA_W+1)-bit difference is the borrow
   always_comb begin
      shifted_s = {rem, quo[DATA_W-1]};
      trial_s   = shifted_s - {1'b0, divisor};
      borrow_s  = trial_s[DATA_W];
      rem_next  = borrow_s ? shifted_s[DATA_W-1:0] : trial_s[DATA_W-1:0];
      quo_next  = {quo[DATA_W-2:0], ~borrow_s};
   end

endmodule

// File: rtl/ex_div_seq.sv
// Multi-cycle DIV/DIVU sequencer: radix-2 restoring divider, one quotient bit
// per cycle, stalling the pipeline until the {HI,LO} result is ready.
module ex_div_seq
   import ex_div_seq_pkg::*;
#(
   parameter int DATA_W = DIV_CYCLES,
   parameter int CNT_W  = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_in,
   input  logic                  signed_in,
   input  logic                  annul_in,
   input  logic [DATA_W-1:0]     dividend_in,
   input  logic [DATA_W-1:0]     divisor_in,
   output logic [2*DATA_W-1:0]   result_out,
   output logic                  ready_out,
   output logic                  stall_req_out
);

   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [DATA_W-1:0] ZERO     = {DATA_W{1'b0}};

   div_state_t        state_r;
   div_state_t        state_nxt;
   logic [CNT_W-1:0]  cnt_r;
   logic [DATA_W-1:0] rem_r;
   logic [DATA_W-1:0] quo_r;
   logic [DATA_W-1:0] dvs_r;
   logic              neg_quo_r;
   logic              neg_rem_r;
   logic              accept_s;
   logic [DATA_W-1:0] dividend_mag_s;
   logic [DATA_W-1:0] divisor_mag_s;
   logic [DATA_W-1:0] rem_step_s;
   logic [DATA_W-1:0] quo_step_s;
   logic [DATA_W-1:0] quo_fix_s;
   logic [DATA_W-1:0] rem_fix_s;

   div_step #(.DATA_W(DATA_W)) u_step (
      .rem      (rem_r),
      .quo      (quo_r),
      .divisor  (dvs_r),
      .rem_next (rem_step_s),
      .quo_next (quo_step_s)
   );

   // Operand magnitudes and the sign-corrected final step result
   always_comb begin
      dividend_mag_s = (signed_in && dividend_in[DATA_W-1]) ? (ZERO - dividend_in) : dividend_in;
      divisor_mag_s  = (signed_in && divisor_in[DATA_W-1])  ? (ZERO - divisor_in)  : divisor_in;
      quo_fix_s      = neg_quo_r ? (ZERO - quo_step_s) : quo_step_s;
      rem_fix_s      = neg_rem_r ? (ZERO - rem_step_s) : rem_step_s;
   end

   // Next-state logic and stall request
   always_comb begin
      state_nxt     = state_r;
      accept_s      = 1'b0;
      stall_req_out = 1'b0;
      case (state_r)
         DIV_IDLE: begin
            if (start_in && !annul_in) begin
               accept_s      = 1'b1;
               stall_req_out = 1'b1;
               state_nxt     = (divisor_in == ZERO) ? DIV_DBZ : DIV_ON;
            end else begin
               state_nxt = DIV_IDLE;
            end
         end
         DIV_DBZ: begin
            stall_req_out = 1'b1;
            state_nxt     = annul_in ? DIV_IDLE : DIV_END;
         end
         DIV_ON: begin
            stall_req_out = 1'b1;
            if (annul_in) begin
               state_nxt = DIV_IDLE;
            end else if (cnt_r == LAST_CNT) begin
               state_nxt = DIV_END;
            end else begin
               state_nxt = DIV_ON;
            end
         end
         DIV_END: begin
            state_nxt = DIV_IDLE;
         end
         default: begin
            state_nxt = DIV_IDLE;
         end
      endcase
   end

   // State, datapath and registered result/ready
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= DIV_IDLE;
         cnt_r      <= {CNT_W{1'b0}};
         rem_r      <= ZERO;
         quo_r      <= ZERO;
         dvs_r      <= ZERO;
         neg_quo_r  <= 1'b0;
         neg_rem_r  <= 1'b0;
         result_out <= {2*DATA_W{1'b0}};
         ready_out  <= 1'b0;
      end else begin
         state_r   <= state_nxt;
         ready_out <= (state_nxt == DIV_END);
         case (state_r)
            DIV_IDLE: begin
               if (accept_s) begin
                  cnt_r     <= {CNT_W{1'b0}};
                  rem_r     <= ZERO;
                  quo_r     <= dividend_mag_s;
                  dvs_r     <= divisor_mag_s;
                  neg_quo_r <= signed_in & (dividend_in[DATA_W-1] ^ divisor_in[DATA_W-1]);
                  neg_rem_r <= signed_in & dividend_in[DATA_W-1];
               end
            end
            DIV_DBZ: begin
               cnt_r <= {CNT_W{1'b0}};
               if (!annul_in) begin
                  result_out <= {2*DATA_W{1'b0}};
               end
            end
            DIV_ON: begin
               if (annul_in) begin
                  cnt_r <= {CNT_W{1'b0}};
               end else begin
                  rem_r <= rem_step_s;
                  quo_r <= quo_step_s;
                  if (cnt_r == LAST_CNT) begin
                     cnt_r      <= {CNT_W{1'b0}};
                     result_out <= {rem_fix_s, quo_fix_s};
                  end else begin
                     cnt_r <= cnt_r + CNT_ONE;
                  end
               end
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ex_div_seq.sv
// Scoreboard bench for ex_div_seq: stimulus pushes expected {HI,LO} results,
// a monitor pops and compares whenever ready_out pulses.
module tb_ex_div_seq;

   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start_in = 1'b0;
   logic           signed_in = 1'b0;
   logic           annul_in = 1'b0;
   logic [W-1:0]   dividend_in = '0;
   logic [W-1:0]   divisor_in = '0;
   logic [2*W-1:0] result_out;
   logic           ready_out;
   logic           stall_req_out;

   int             total = 0;
   int             bad = 0;
   int             cyc = 0;
   int             last_ready = 0;
   int             first_ready = 0;
   logic [2*W-1:0] exp_q[$];

   ex_div_seq #(.DATA_W(W), .CNT_W(6)) dut (
      .clk           (clk),
      .rst           (rst),
      .start_in      (start_in),
      .signed_in     (signed_in),
      .annul_in      (annul_in),
      .dividend_in   (dividend_in),
      .divisor_in    (divisor_in),
      .result_out    (result_out),
      .ready_out     (ready_out),
      .stall_req_out (stall_req_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk64(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chkint(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // Monitor: every ready pulse must match the oldest pending expectation
   always @(negedge clk) begin
      if (ready_out === 1'b1) begin
         logic [2*W-1:0] e;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ready: got ready=1 want no pending result (cycle %0d)", cyc);
         end else begin
            e = exp_q.pop_front();
            chk64("result", result_out, e);
         end
      end
   end

   task automatic run_div(input string name, input logic sgn, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [2*W-1:0] exp_res, input int exp_lat);
      bit seen;
      @(posedge clk); #1;
      start_in    = 1'b1;
      signed_in   = sgn;
      dividend_in = a;
      divisor_in  = b;
      exp_q.push_back(exp_res);
      @(negedge clk);
      chk1({name, "_stall_start"}, stall_req_out, 1'b1);
      @(posedge clk); #1;
      start_in    = 1'b0;
      signed_in   = ~sgn;
      dividend_in = $urandom;
      divisor_in  = $urandom;
      seen = 1'b0;
      for (int k = 1; k <= 100 && !seen; k++) begin
         @(negedge clk);
         chk1({name, "_stall"}, stall_req_out, (k < exp_lat));
         if (ready_out === 1'b1) begin
            seen = 1'b1;
            chkint({name, "_latency"}, k, exp_lat);
            last_ready = cyc;
         end
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: got no ready within 100 cycles want ready at %0d", name, exp_lat);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got simulation still running want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk64("reset_result", result_out, 64'h0);
      chk1("reset_ready", ready_out, 1'b0);
      chk1("reset_stall", stall_req_out, 1'b0);
      #2 rst = 1'b0;

      run_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 33);
      run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
      run_div("divu_m7_2", 1'b0, 32'hFFFF_FFF9, 32'h2, {32'h1, 32'h7FFF_FFFC}, 33);
      run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, 33);
      run_div("div_5_0", 1'b1, 32'd5, 32'd0, 64'h0, 2);
      run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33);

      // start together with annul is refused
      @(posedge clk); #1;
      start_in = 1'b1; annul_in = 1'b1; signed_in = 1'b0;
      dividend_in = 32'd9; divisor_in = 32'd3;
      @(negedge clk);
      chk1("annul_start_stall", stall_req_out, 1'b0);
      @(posedge clk); #1;
      start_in = 1'b0; annul_in = 1'b0;
      @(negedge clk);
      chk1("annul_start_idle_stall", stall_req_out, 1'b0);

      // abort at iteration 10: no ready, stall drops, result held
      @(posedge clk); #1;
      start_in = 1'b1; signed_in = 1'b0; dividend_in = 32'd1000; divisor_in = 32'd7;
      @(posedge clk); #1;
      start_in = 1'b0;
      repeat (10) @(posedge clk);
      #1 annul_in = 1'b1;
      @(negedge clk);
      chk1("annul_on_stall", stall_req_out, 1'b1);
      @(posedge clk); #1;
      annul_in = 1'b0;
      @(negedge clk);
      chk1("annul_stall_low", stall_req_out, 1'b0);
      chk1("annul_no_ready", ready_out, 1'b0);
      chk64("annul_result_held", result_out, {32'h0, 32'h8000_0000});
      repeat (40) @(negedge clk);
      chk64("annul_result_still_held", result_out, {32'h0, 32'h8000_0000});

      run_div("divu_9_3", 1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 33);

      // asynchronous reset in the middle of a division
      @(posedge clk); #1;
      start_in = 1'b1; signed_in = 1'b0; dividend_in = 32'd1000; divisor_in = 32'd3;
      @(posedge clk); #1;
      start_in = 1'b0;
      repeat (5) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk64("rst_mid_result", result_out, 64'h0);
      chk1("rst_mid_ready", ready_out, 1'b0);
      chk1("rst_mid_stall", stall_req_out, 1'b0);
      @(negedge clk); #2 rst = 1'b0;
      repeat (40) @(negedge clk);
      chk64("rst_no_late_result", result_out, 64'h0);

      // back-to-back divisions
      run_div("divu_10_3", 1'b0, 32'd10, 32'd3, {32'h1, 32'h3}, 33);
      first_ready = last_ready;
      run_div("divu_20_6", 1'b0, 32'd20, 32'd6, {32'h2, 32'h3}, 33);
      chkint("b2b_gap", last_ready - first_ready, 34);
      @(negedge clk);
      chk1("ready_one_cycle", ready_out, 1'b0);
      chk64("result_held_after_ready", result_out, {32'h2, 32'h3});
      repeat (3) @(negedge clk);
      chkint("scoreboard_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
